// File: rtl/rom_arb_pkg.sv
// Shared types for the IF/LS instruction-ROM arbiter: response owner tag, sizing constants
// and the word-read range check.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  typedef struct packed {
    owner_e own;
    logic   err;
  } resp_tag_t;

  localparam int unsigned ROM_BYTES_DEF = 4096;
  localparam int unsigned WAIT_W        = 4;

  // addr+3 is formed in 33 bits so addresses near 0xFFFFFFFF cannot wrap into range.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned rom_bytes);
    logic [32:0] last_byte;
    last_byte = {1'b0, addr} + 33'd3;
    return last_byte >= 33'(rom_bytes);
  endfunction

endpackage

// File: rtl/rom_arb_starve.sv
// Saturating count of consecutive grants LS has lost to IF; force_ls forces the next LS win.
// Purely registered count, force_ls is a decode of the current count (no input-to-output path).
module rom_arb_starve
  import rom_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ls_req,
  input  logic ls_gnt,
  input  logic if_gnt,
  output logic force_ls
);

  localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!ls_req || ls_gnt) begin
      cnt_d = '0;
    end else if (if_gnt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_ls = (cnt_q == CNT_MAX);

endmodule

// File: rtl/rom_arb.sv
// Shares the single-port instruction ROM between fetch (IF, priority) and load/store (LS).
// Grant is combinational on req; response one cycle later; a losing requester holds req.
module rom_arb
  import rom_arb_pkg::*;
#(
  parameter int unsigned ROM_BYTES = ROM_BYTES_DEF,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic        if_err_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic [31:0] ls_addr_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic        ls_err_o,
  output logic [31:0] ls_rdata_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i
);

  logic        force_ls;
  logic        if_live;
  logic        ls_live;
  logic        if_win;
  logic        ls_win;
  logic        gnt_any;
  logic        gnt_err;
  logic [31:0] gnt_addr;
  logic [31:0] rom_addr_q;
  resp_tag_t   tag_d;
  resp_tag_t   tag_q;
  logic        if_resp;
  logic        ls_resp;

  // Grants are gated by rst_n so every output reads 0 for the whole reset window.
  assign if_live = if_req_i & ~if_flush_i & rst_n;
  assign ls_live = ls_req_i & rst_n;

  assign ls_win  = ls_live & (~if_live | force_ls);
  assign if_win  = if_live & ~ls_win;
  assign gnt_any = ls_win | if_win;

  assign if_gnt_o = if_win;
  assign ls_gnt_o = ls_win;

  rom_arb_starve #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .ls_req   (ls_live),
    .ls_gnt   (ls_win),
    .if_gnt   (if_win),
    .force_ls (force_ls)
  );

  always_comb begin
    gnt_addr = if_addr_i;
    gnt_err  = 1'b0;
    tag_d    = '{own: OWN_NONE, err: 1'b0};
    if (ls_win) begin
      gnt_addr = ls_addr_i;
      gnt_err  = addr_bad(ls_addr_i, ROM_BYTES);
      tag_d    = '{own: OWN_LS, err: gnt_err};
    end else if (if_win) begin
      gnt_err  = addr_bad(if_addr_i, ROM_BYTES) | (|if_addr_i[1:0]);
      tag_d    = '{own: OWN_IF, err: gnt_err};
    end
  end

  // Errored or absent grants leave the ROM looking at the last legal address.
  assign rom_addr_o = (gnt_any && !gnt_err) ? gnt_addr : rom_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      tag_q      <= '{own: OWN_NONE, err: 1'b0};
    end else begin
      rom_addr_q <= rom_addr_o;
      tag_q      <= tag_d;
    end
  end

  assign if_resp = (tag_q.own == OWN_IF) & ~if_flush_i;
  assign ls_resp = (tag_q.own == OWN_LS);

  assign if_rvalid_o = if_resp;
  assign if_err_o    = if_resp & tag_q.err;
  assign if_rdata_o  = (if_resp && !tag_q.err) ? rom_data_i : '0;

  assign ls_rvalid_o = ls_resp;
  assign ls_err_o    = ls_resp & tag_q.err;
  assign ls_rdata_o  = (ls_resp && !tag_q.err) ? rom_data_i : '0;

endmodule

// File: tb/tb_rom_arb.sv
// Directed plus random bench for rom_arb against a transaction-level arbitration model.
module tb_rom_arb;

  localparam int unsigned RB = 4096;
  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic [31:0] ls_addr = '0;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = '0;

  logic [7:0]  mem [RB];

  int          total = 0;
  int          bad = 0;

  // Model state: losses in a row, pending response owner (0 none, 1 IF, 2 LS), its data.
  int          lose;
  int          pend_own;
  bit          pend_err;
  logic [31:0] pend_data;
  logic [31:0] held_addr;
  bit          last_if_g;
  bit          last_ls_g;

  rom_arb #(.ROM_BYTES(RB), .MAX_WAIT(MW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_flush_i  (if_flush),
    .if_gnt_o    (if_gnt),
    .if_rvalid_o (if_rvalid),
    .if_err_o    (if_err),
    .if_rdata_o  (if_rdata),
    .ls_req_i    (ls_req),
    .ls_addr_i   (ls_addr),
    .ls_gnt_o    (ls_gnt),
    .ls_rvalid_o (ls_rvalid),
    .ls_err_o    (ls_err),
    .ls_rdata_o  (ls_rdata),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a > RB - 4) return 32'h0;
    return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
    return (longint'(a) + 64'd3) >= longint'(RB);
  endfunction

  always @(posedge clk) rom_data <= word(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_if_gnt"}, 32'(if_gnt), 32'h0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'h0);
    chk({tag, "_if_err"}, 32'(if_err), 32'h0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_ls_gnt"}, 32'(ls_gnt), 32'h0);
    chk({tag, "_ls_rvalid"}, 32'(ls_rvalid), 32'h0);
    chk({tag, "_ls_err"}, 32'(ls_err), 32'h0);
    chk({tag, "_ls_rdata"}, ls_rdata, 32'h0);
    chk({tag, "_rom_addr"}, rom_addr, 32'h0);
  endtask

  task automatic model_reset();
    lose      = 0;
    pend_own  = 0;
    pend_err  = 1'b0;
    pend_data = '0;
    held_addr = '0;
    last_if_g = 1'b0;
    last_ls_g = 1'b0;
  endtask

  // One clock: check this cycle's outputs at the falling edge, advance the model, land at posedge+1.
  task automatic step();
    bit          if_ok, ls_g, if_g, g_err;
    logic [31:0] g_addr, exp_rom;
    bit          exp_ifv, exp_lsv;
    @(negedge clk);
    if_ok  = if_req && !if_flush;
    ls_g   = ls_req && (!if_ok || lose == MW);
    if_g   = if_ok && !ls_g;
    g_addr = ls_g ? ls_addr : if_addr;
    g_err  = ls_g ? out_of_range(ls_addr)
           : if_g ? (out_of_range(if_addr) || if_addr[1:0] != 2'b00) : 1'b0;
    exp_rom = ((ls_g || if_g) && !g_err) ? g_addr : held_addr;
    exp_ifv = (pend_own == 1) && !if_flush;
    exp_lsv = (pend_own == 2);

    chk("if_gnt", 32'(if_gnt), 32'(if_g));
    chk("ls_gnt", 32'(ls_gnt), 32'(ls_g));
    chk("rom_addr", rom_addr, exp_rom);
    chk("if_rvalid", 32'(if_rvalid), 32'(exp_ifv));
    chk("if_err", 32'(if_err), 32'(exp_ifv && pend_err));
    chk("if_rdata", if_rdata, (exp_ifv && !pend_err) ? pend_data : 32'h0);
    chk("ls_rvalid", 32'(ls_rvalid), 32'(exp_lsv));
    chk("ls_err", 32'(ls_err), 32'(exp_lsv && pend_err));
    chk("ls_rdata", ls_rdata, (exp_lsv && !pend_err) ? pend_data : 32'h0);

    if (ls_req && if_g) lose = (lose < MW) ? lose + 1 : MW;
    else if (!ls_req || ls_g) lose = 0;
    pend_own  = ls_g ? 2 : (if_g ? 1 : 0);
    pend_err  = g_err;
    pend_data = word(exp_rom);
    held_addr = exp_rom;
    last_if_g = if_g;
    last_ls_g = ls_g;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr(input bit is_if);
    int unsigned r;
    logic [31:0] a;
    r = $urandom % 16;
    if (r == 0) return 32'hFFFF_FFFC + 32'($urandom % 4);
    if (r == 1) return 32'(RB - 6) + 32'($urandom % 6);
    a = 32'($urandom % RB);
    if (is_if && r != 2) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    for (int i = 0; i < RB; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 5));
    mem[0] = 8'h13; mem[1] = 8'h04; mem[2] = 8'h00; mem[3] = 8'h00;
    model_reset();

    // Reset state
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();

    // IF stream 0x0, 0x4, 0x8
    if_req = 1'b1; if_addr = 32'h0;
    step();
    chk("if_word0", if_rdata, 32'h0000_0413);
    if_addr = 32'h4;
    step();
    if_addr = 32'h8;
    step();
    chk("if_word8", if_rdata, {mem[11], mem[10], mem[9], mem[8]});
    if_req = 1'b0;
    step();

    // Starvation: both held; pattern IF x4 then LS
    if_req = 1'b1; if_addr = 32'h10;
    ls_req = 1'b1; ls_addr = 32'h101;
    for (int i = 0; i < 10; i++) begin
      chk("starve_seq", 32'(ls_gnt), 32'((i % 5) == 4));
      step();
      if ((i % 5) == 4) chk("ls_unaligned", ls_rdata, {mem[32'h104], mem[32'h103], mem[32'h102], mem[32'h101]});
    end
    if_req = 1'b0; ls_req = 1'b0;
    step();

    // Range and alignment errors
    ls_req = 1'b1; ls_addr = 32'hFFC;
    step();
    chk("ls_top_err", 32'(ls_err), 32'h0);
    chk("ls_top_data", ls_rdata, {mem[4095], mem[4094], mem[4093], mem[4092]});
    ls_addr = 32'hFFD;
    step();
    chk("ls_over_err", 32'(ls_err), 32'h1);
    chk("ls_over_data", ls_rdata, 32'h0);
    chk("ls_over_addr", rom_addr, 32'hFFC);
    ls_addr = 32'hFFFF_FFFE;
    step();
    chk("ls_wrap_err", 32'(ls_err), 32'h1);
    ls_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h2;
    step();
    chk("if_misalign_err", 32'(if_err), 32'h1);
    if_req = 1'b0;
    step();

    // Flush
    if_req = 1'b1; if_addr = 32'h20;
    step();
    if_flush = 1'b1; if_addr = 32'h24;
    ls_req = 1'b1; ls_addr = 32'h30;
    #1;
    chk("flush_kill", 32'(if_rvalid), 32'h0);
    chk("flush_if_gnt", 32'(if_gnt), 32'h0);
    chk("flush_ls_gnt", 32'(ls_gnt), 32'h1);
    step();
    chk("flush_ls_resp", 32'(ls_rvalid), 32'h1);
    chk("flush_ls_data", ls_rdata, {mem[32'h33], mem[32'h32], mem[32'h31], mem[32'h30]});
    if_flush = 1'b0; ls_req = 1'b0;
    step();
    if_req = 1'b0;
    step();

    // Reset in the middle of a read
    if_req = 1'b1; if_addr = 32'h8;
    step();
    #1;
    rst_n = 1'b0; if_req = 1'b0;
    #1;
    chk_zero("midrst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_addr = 32'h44;
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_starve", 32'(ls_gnt), 32'(i == 4));
      step();
    end
    ls_req = 1'b0;

    // Idle hold after a read of 0x40
    step();
    if_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_addr", rom_addr, 32'h40);
    end

    // Random traffic honouring the hold-until-granted rule
    last_if_g = 1'b0; last_ls_g = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!if_req || last_if_g) begin
        if_req  = ($urandom % 3) != 0;
        if_addr = rnd_addr(1'b1);
      end
      if (!ls_req || last_ls_g) begin
        ls_req  = ($urandom % 3) != 0;
        ls_addr = rnd_addr(1'b0);
      end
      if_flush = ($urandom % 8) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_arb.md
# rom_arb

Two-port arbiter that shares the single-read-port byte-addressed instruction ROM between the core's instruction-fetch path (IF) and the load/store unit (LS) for constant-data reads. Sits between rv32core and the ROM:
- It drives the ROM address.
- It tags each one-cycle-latency ROM read with its owner.
- It returns data, valid and error to the correct requester.

IF normally has priority. A starvation counter guarantees LS forward progress.

## Interface
- `ROM_BYTES`, default 4096: ROM size in bytes. A read is legal only if addr+3 < ROM_BYTES.
- `MAX_WAIT`, default 4: consecutive IF grants LS may lose before it is forced to win. Range 1..15.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `if_req_i` input 1: IF read request. Held until granted.
- `if_addr_i` input 32: IF byte address. Must be word-aligned.
- `if_flush_i` input 1: pipeline redirect. Kills any IF response due next cycle.
- `if_gnt_o` output 1: IF request accepted this cycle.
- `if_rvalid_o` output 1: IF response valid.
- `if_err_o` output 1: IF response is an error (range or alignment).
- `if_rdata_o` output 32: IF read data.
- `ls_req_i` input 1: LS read request. Held until granted.
- `ls_addr_i` input 32: LS byte address. Any alignment.
- `ls_gnt_o` output 1: LS request accepted.
- `ls_rvalid_o` output 1: LS response valid.
- `ls_err_o` output 1: LS response is an error (range).
- `ls_rdata_o` output 32: LS read data, little-endian from addr.
- `rom_addr_o` output 32: byte address to ROM.
- `rom_data_i` input 32: ROM registered output. Valid one cycle after the address.

## Operation
- **Grant (combinational, each cycle):**
  - LS wins if `ls_req_i` and (not `if_req_i`, or starve_cnt == MAX_WAIT).
  - Otherwise IF wins if `if_req_i`.
  - At most one grant per cycle.
- **Request check at grant:**
  - Out-of-range: addr > ROM_BYTES-4.
  - IF misaligned: if_addr_i[1:0] != 0.
  - An erroring request is still granted, but is marked err and does not change `rom_addr_o`.
- **ROM address:** `rom_addr_o` = granted non-error address. With no valid grant it holds its previous value (reset 0).
- **Owner register:** one of OWN_NONE, OWN_IF, OWN_LS, plus an err flag. Loaded every cycle from the grant result. It selects the response next cycle.
- **Response:**
  - The owner's rvalid is asserted for exactly one cycle.
  - rdata = `rom_data_i`, or 0 when err.
  - The other port's rvalid = 0.
  - rdata of a non-valid port is 0.
- **Starvation counter (4 bits):**
  - Increments when `ls_req_i` is high and IF is granted.
  - Clears when LS is granted or `ls_req_i` is low.
  - Saturates at MAX_WAIT.
- **Flush:**
  - `if_flush_i` high while owner == OWN_IF suppresses `if_rvalid_o`/`if_err_o` that cycle.
  - `if_flush_i` high in a grant cycle also blocks the IF grant that cycle. LS may win instead.
  - Flush never affects LS.

## Timing
- **Latency:** grant in cycle N, response in cycle N+1. Back-to-back grants every cycle are allowed, giving one read per cycle of throughput.
- **Reset values:**
  - Every output is 0.
  - Owner = OWN_NONE.
  - starve_cnt = 0.
- **Reset mid-operation:** an in-flight response is discarded and no rvalid follows after reset deasserts.
- **Handshake:**
  - `*_gnt_o` depends on `*_req_i` in the same cycle. There is no registered request path.
  - A requester must not change addr while req is high and gnt is low.
- **Simultaneous IF+LS requests with starve_cnt < MAX_WAIT:** IF granted, counter increments.
- **Simultaneous IF+LS requests with starve_cnt == MAX_WAIT:** LS granted, counter clears.
- **Boundary addresses:**
  - Addr = ROM_BYTES-4 is legal.
  - ROM_BYTES-3 is an error.
  - 32-bit addr wrap (0xFFFFFFFE) is an error; the addr+3 overflow must be computed in 33 bits.

## Structure
- `rom_arb_pkg`:
  - owner enum (OWN_NONE=0, OWN_IF=1, OWN_LS=2).
  - default ROM_BYTES.
  - MAX_WAIT width constant.
- Sub-module `rom_arb_starve` holds the saturating starvation counter and outputs `force_ls`.
- Grant logic, range check and the owner register stay in `rom_arb`.

## Test plan
- **IF stream:** IF reqs at 0x0, 0x4, 0x8 every cycle with ROM preloaded (0x00000413 at 0). Expect gnt each cycle, `if_rvalid_o` on N+1 with matching words, `ls_rvalid_o` = 0.
- **Starvation:** IF and LS held high continuously, MAX_WAIT=4. Expect 4 IF grants, then 1 LS grant, repeating. LS data for addr 0x101 = bytes 0x101..0x104 little-endian.
- **Range and alignment errors:**
  - LS addr 0xFFC (ROM_BYTES=4096): valid data, err=0.
  - LS addr 0xFFD: `ls_err_o`=1, rdata=0, `rom_addr_o` unchanged.
  - IF addr 0x2: `if_err_o`=1.
- **Flush:** IF granted at N, `if_flush_i`=1 at N+1. Expect no `if_rvalid_o` at N+1. A concurrent LS req is granted at N+1 and answered at N+2.
- **Reset mid-read:** grant at N, `rst_n` low asynchronously before N+1. All outputs 0 immediately, no rvalid after release, starve_cnt = 0.
- **Idle hold:** no requests for 5 cycles after a read of 0x40. `rom_addr_o` stays 0x40, all rvalid = 0.
